mem_arbiter: RTL and testbench

Two-port arbiter that shares one single-ported memory bus between the pipeline's instruction-fetch port and its data (MEM-stage) port. It accepts held-level requests from both ports, grants one at a time, and drives a registered bus transaction that waits for the memory's acknowledge. It returns read data with a one-cycle ready pulse and raises per-port stall signals that feed the hazard logic. It sits between the datapath's fetch/memory stages and the external memory.

---
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port fetch/data arbiter sharing one single-ported memory bus.
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_ready,
    input  logic              data_req,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_ready,
    output logic              stall_inst,
    output logic              stall_data,
    output logic              bus_req,
    output logic [3:0]        bus_wen,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic [3:0]        bus_wen_q, bus_wen_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              inst_ready_q, inst_ready_d;
    logic              data_ready_q, data_ready_d;
    logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

    logic starve;
    logic grant_data;
    logic grant_inst;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] cnt_q, cnt_d;

    assign starve = inst_req & (cnt_q == LIMIT);

    // Counts data grants that overtook a waiting fetch.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            if (!inst_req || grant_inst) begin
                cnt_d = 4'd0;
            end else if (grant_data) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end
`else
    logic [3:0] unused_limit;

    assign unused_limit = 4'(STARVE_LIMIT);
    assign starve       = 1'b0;
`endif

    assign grant_data = data_req & ~starve;
    assign grant_inst = inst_req & (~data_req | starve);

    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        bus_wen_d    = bus_wen_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        inst_ready_d = 1'b0;
        data_ready_d = 1'b0;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;

        unique case (state_q)
            IDLE: begin
                unique case (1'b1)
                    grant_data: begin
                        state_d     = DATA;
                        bus_req_d   = 1'b1;
                        bus_addr_d  = data_addr;
                        bus_wen_d   = data_wen;
                        bus_wdata_d = data_wdata;
                    end
                    grant_inst: begin
                        state_d     = INST;
                        bus_req_d   = 1'b1;
                        bus_addr_d  = inst_addr;
                        bus_wen_d   = 4'b0000;
                        bus_wdata_d = '0;
                    end
                    default: ;
                endcase
            end
            INST: begin
                if (bus_ack) begin
                    inst_rdata_d = bus_rdata;
                    inst_ready_d = 1'b1;
                    bus_req_d    = 1'b0;
                    state_d      = DONE;
                end
            end
            DATA: begin
                if (bus_ack) begin
                    // Stores leave the last load value in place.
                    if (bus_wen_q == 4'b0000) begin
                        data_rdata_d = bus_rdata;
                    end
                    data_ready_d = 1'b1;
                    bus_req_d    = 1'b0;
                    state_d      = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bus_req_q    <= 1'b0;
            bus_wen_q    <= 4'b0000;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            inst_ready_q <= 1'b0;
            data_ready_q <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
`ifdef ARB_STARVE_GUARD_EN
            cnt_q        <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_wen_q    <= bus_wen_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            inst_ready_q <= inst_ready_d;
            data_ready_q <= data_ready_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
`ifdef ARB_STARVE_GUARD_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign bus_req    = bus_req_q;
    assign bus_wen    = bus_wen_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign inst_ready = inst_ready_q;
    assign data_ready = data_ready_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;
    assign stall_inst = inst_req & ~inst_ready_q;
    assign stall_data = data_req & ~data_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reads, store, priority,
// async reset mid-transaction and spurious acks.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ready;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ready;
    logic        stall_inst;
    logic        stall_data;
    logic        bus_req;
    logic [3:0]  bus_wen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .inst_req(inst_req),
        .inst_addr(inst_addr),
        .inst_rdata(inst_rdata),
        .inst_ready(inst_ready),
        .data_req(data_req),
        .data_wen(data_wen),
        .data_addr(data_addr),
        .data_wdata(data_wdata),
        .data_rdata(data_rdata),
        .data_ready(data_ready),
        .stall_inst(stall_inst),
        .stall_data(stall_data),
        .bus_req(bus_req),
        .bus_wen(bus_wen),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ack(bus_ack)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam int NG = 10;
    logic [NG-1:0] exp_inst;
    int  n_grant;
    int  budget;
    logic prev_req;

    initial begin
        rst        = 1'b1;
        inst_req   = 1'b0;
        inst_addr  = '0;
        data_req   = 1'b0;
        data_wen   = 4'b0000;
        data_addr  = '0;
        data_wdata = '0;
        bus_rdata  = '0;
        bus_ack    = 1'b0;
        step();
        step();
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wen", {28'd0, bus_wen}, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_ready", {30'd0, inst_ready, data_ready}, 32'd0);
        chk("rst_inst_rdata", inst_rdata, 32'd0);
        chk("rst_data_rdata", data_rdata, 32'd0);
        rst = 1'b0;
        step();

        // Fetch read, memory acks two cycles after bus_req rises.
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0040;
        #1;
        chk("f_stall_pre", {31'd0, stall_inst}, 32'd1);
        step();
        chk("f_bus_req", {31'd0, bus_req}, 32'd1);
        chk("f_bus_addr", bus_addr, 32'h40);
        chk("f_bus_wen", {28'd0, bus_wen}, 32'd0);
        step();
        chk("f_stall_wait", {31'd0, stall_inst}, 32'd1);
        step();
        bus_ack   = 1'b1;
        bus_rdata = 32'h8C22_0004;
        chk("f_no_ready", {31'd0, inst_ready}, 32'd0);
        step();
        bus_ack = 1'b0;
        chk("f_ready", {31'd0, inst_ready}, 32'd1);
        chk("f_rdata", inst_rdata, 32'h8C22_0004);
        chk("f_stall_done", {31'd0, stall_inst}, 32'd0);
        chk("f_bus_req_clr", {31'd0, bus_req}, 32'd0);
        inst_req = 1'b0;
        step();
        chk("f_ready_pulse", {31'd0, inst_ready}, 32'd0);

        // Simultaneous requests: data first, then fetch.
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0080;
        data_req  = 1'b1;
        data_wen  = 4'b0000;
        data_addr = 32'h0000_0100;
        step();
        chk("p_first_addr", bus_addr, 32'h100);
        bus_ack   = 1'b1;
        bus_rdata = 32'h1111_2222;
        step();
        chk("p_data_ready", {30'd0, data_ready, inst_ready}, 32'd2);
        chk("p_data_rdata", data_rdata, 32'h1111_2222);
        chk("p_stall_inst", {30'd0, stall_inst, stall_data}, 32'd2);
        data_req = 1'b0;
        bus_ack  = 1'b0;
        step();
        chk("p_idle", {31'd0, bus_req}, 32'd0);
        step();
        chk("p_inst_addr", bus_addr, 32'h80);
        chk("p_inst_req", {31'd0, bus_req}, 32'd1);
        bus_ack   = 1'b1;
        bus_rdata = 32'h3333_4444;
        step();
        bus_ack = 1'b0;
        chk("p_inst_ready", {31'd0, inst_ready}, 32'd1);
        chk("p_inst_rdata", inst_rdata, 32'h3333_4444);
        inst_req = 1'b0;
        step();

        // Store completes like a read, load data untouched.
        data_req   = 1'b1;
        data_wen   = 4'b0011;
        data_addr  = 32'h0000_0200;
        data_wdata = 32'hDEAD_BEEF;
        step();
        chk("s_wen", {28'd0, bus_wen}, 32'd3);
        chk("s_wdata", bus_wdata, 32'hDEAD_BEEF);
        chk("s_addr", bus_addr, 32'h200);
        data_wdata = 32'h0;
        data_addr  = 32'h0;
        step();
        chk("s_wdata_hold", bus_wdata, 32'hDEAD_BEEF);
        chk("s_wen_hold", {28'd0, bus_wen}, 32'd3);
        chk("s_addr_hold", bus_addr, 32'h200);
        bus_ack   = 1'b1;
        bus_rdata = 32'h5555_5555;
        step();
        bus_ack = 1'b0;
        chk("s_ready", {31'd0, data_ready}, 32'd1);
        chk("s_rdata_kept", data_rdata, 32'h1111_2222);
        chk("s_bus_req_clr", {31'd0, bus_req}, 32'd0);
        data_req = 1'b0;
        data_wen = 4'b0000;
        step();

        // Both requests held; memory acks in every granted cycle.
`ifdef ARB_STARVE_GUARD_EN
        exp_inst = 10'b10000_10000;
`else
        exp_inst = 10'b00000_00000;
`endif
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0080;
        data_req  = 1'b1;
        data_addr = 32'h0000_0300;
        bus_rdata = 32'h0;
        n_grant   = 0;
        budget    = 0;
        prev_req  = 1'b0;
        while (n_grant < NG && budget < 100) begin
            step();
            budget++;
            bus_ack = bus_req;
            if (bus_req && !prev_req) begin
                chk($sformatf("g%0d", n_grant),
                    {31'd0, bus_addr == 32'h80},
                    {31'd0, exp_inst[n_grant]});
                n_grant++;
            end
            prev_req = bus_req;
        end
        chk("g_count", n_grant, NG);
        inst_req = 1'b0;
        data_req = 1'b0;
        step();
        bus_ack = 1'b0;
        step();
        step();
        chk("g_quiet", {31'd0, bus_req}, 32'd0);

        // Async reset while a data read waits for its ack.
        data_req  = 1'b1;
        data_addr = 32'h0000_0400;
        step();
        chk("r_granted", {31'd0, bus_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("r_bus_req_async", {31'd0, bus_req}, 32'd0);
        chk("r_bus_addr", bus_addr, 32'd0);
        step();
        rst       = 1'b0;
        data_req  = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 32'h7777_7777;
        step();
        bus_ack = 1'b0;
        chk("r_no_ready", {30'd0, data_ready, inst_ready}, 32'd0);
        chk("r_data_rdata", data_rdata, 32'd0);
        chk("r_inst_rdata", inst_rdata, 32'd0);
        chk("r_idle", {31'd0, bus_req}, 32'd0);
        step();
        chk("r_no_ready2", {30'd0, data_ready, inst_ready}, 32'd0);

        // Spurious ack in IDLE.
        bus_ack   = 1'b1;
        bus_rdata = 32'hAAAA_AAAA;
        step();
        bus_ack = 1'b0;
        step();
        chk("sp_ready", {30'd0, data_ready, inst_ready}, 32'd0);
        chk("sp_data_rdata", data_rdata, 32'd0);
        chk("sp_inst_rdata", inst_rdata, 32'd0);
        chk("sp_bus_req", {31'd0, bus_req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
